// File: rtl/aes_pkg.sv
// aes_pkg: shared types and helpers for the AES decrypt core.
//   aes_mode_e   : key-size selector sampled when a block is accepted
//   NR_*         : round counts for the three key sizes
//   aes_fsm_e    : core control states
//   mode_to_nr   : key-size selector -> round count
//   GF(2^8) helpers used by the inverse round (inverse S-box, InvMixColumns)
package aes_pkg;

  typedef enum logic [1:0] {
    MODE_128     = 2'b00,
    MODE_192     = 2'b01,
    MODE_256     = 2'b10,
    MODE_256_ALT = 2'b11
  } aes_mode_e;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } aes_fsm_e;

  // The spare encoding behaves as AES-256.
  function automatic logic [3:0] mode_to_nr(input aes_mode_e m);
    case (m)
      MODE_128: return NR_128;
      MODE_192: return NR_192;
      default:  return NR_256;
    endcase
  endfunction

  // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box needs).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  // Inverse S-box: undo the affine map, then invert in GF(2^8).
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] a;
    a = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(a);
  endfunction

  // One column of InvMixColumns; bits [31:24] hold row 0.
  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    b1 = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    b2 = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    b3 = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/aes_inv_rounddata.sv
// aes_inv_rounddata: one combinational inverse AES round.
//   first      : initial AddRoundKey only
//   last       : final round, InvMixColumns skipped
//   state      : current 128-bit state, bit 127 = byte 0 (bytes column-major)
//   round_key  : round key for this round
//   next_state : state after this round
module aes_inv_rounddata
  import aes_pkg::*;
(
  input  logic         first,
  input  logic         last,
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  output logic [127:0] next_state
);

  logic [127:0] shifted;
  logic [127:0] subbed;
  logic [127:0] keyed;
  logic [127:0] mixed;

  // Byte i sits at row i%4, column i/4. InvShiftRows moves row r right by r,
  // so output (r,c) takes input (r, (c-r) mod 4).
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int DST = 4 * c + r;
      localparam int SRC = 4 * ((c - r + 4) % 4) + r;
      assign shifted[127-8*DST -: 8] = state[127-8*SRC -: 8];
      assign subbed[127-8*DST -: 8]  = inv_sbox(shifted[127-8*DST -: 8]);
    end
    assign mixed[127-32*c -: 32] = inv_mix_column(keyed[127-32*c -: 32]);
  end

  assign keyed = subbed ^ round_key;

  always_comb begin
    next_state = mixed;
    if (first)     next_state = state ^ round_key;
    else if (last) next_state = keyed;
  end

endmodule

// File: rtl/aes_decrypt_core.sv
// aes_decrypt_core: iterative AES-128/192/256 decryption, one round per cycle.
//   clk, rst_n     : clock, asynchronous active-low reset
//   mode           : key size, sampled on accept (00/01/10, 11 = AES-256)
//   in_valid/ready : ciphertext handshake; a block moves on in_valid & in_ready
//   data_in        : ciphertext, bit 127 = byte 0
//   rk_index       : round key wanted this cycle (0 outside ROUND)
//   round_key      : key for rk_index, supplied combinationally by a key store
//   out_valid/ready: plaintext handshake; data_out holds while out_valid & !out_ready
//   data_out       : plaintext (0 outside DONE)
//   busy           : high while rounds are running
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high at the rising edge; valid never waits on ready, and in_ready depends
// only on the core's own state, never on out_ready.
module aes_decrypt_core
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic [3:0]   rk_index,
  input  logic [127:0] round_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  aes_fsm_e     fsm_q, fsm_d;
  logic [3:0]   cnt_q;
  logic [3:0]   nr_q;
  logic [127:0] state_q;
  logic [127:0] round_out;
  logic         first;
  logic         last;

  // Counter runs Nr..0; Nr >= 10 so first and last never coincide.
  assign first = (cnt_q == nr_q);
  assign last  = (cnt_q == 4'd0);

  aes_inv_rounddata u_round (
    .first      (first),
    .last       (last),
    .state      (state_q),
    .round_key  (round_key),
    .next_state (round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= ST_IDLE;
      cnt_q   <= 4'd0;
      nr_q    <= 4'd0;
      state_q <= 128'd0;
    end else begin
      fsm_q <= fsm_d;
      case (fsm_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_q <= data_in;
            nr_q    <= mode_to_nr(aes_mode_e'(mode));
            cnt_q   <= mode_to_nr(aes_mode_e'(mode));
          end
        end
        ST_ROUND: begin
          state_q <= round_out;
          // Holding at 0 on the final round keeps the counter from wrapping.
          if (!last) cnt_q <= cnt_q - 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    rk_index  = 4'd0;
    data_out  = 128'd0;
    case (fsm_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) fsm_d = ST_ROUND;
      end
      ST_ROUND: begin
        busy     = 1'b1;
        rk_index = cnt_q;
        if (last) fsm_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        data_out  = state_q;
        if (out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Bench for aes_decrypt_core. The reference is a forward AES encryptor with
// its own key schedule; the bench acts as the external round-key store.
module tb_aes_decrypt_core;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   mode;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic [3:0]   rk_index;
  logic [127:0] round_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic         busy;

  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY_128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY_256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT_256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic [7:0]   sbox_tab[256];
  logic [127:0] rk_tab[15];
  logic [3:0]   rk_seen[$];
  logic [127:0] exp_q[$];
  int           n_pass;
  int           n_checks;

  aes_decrypt_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .rk_index  (rk_index),
    .round_key (round_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- key store ----------------
  assign round_key = (rk_index <= 4'd14) ? rk_tab[rk_index] : 128'd0;

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00; aa = a; bb = b;
    while (bb != 8'h00) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Forward S-box from first principles: brute-force inverse, then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] key, input int nk);
    logic [31:0] w[60];
    logic [31:0] temp;
    logic [7:0]  rcon;
    int          nr;
    nr = nk + 6;
    rcon = 8'h01;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) begin
        w[i] = key[255 - 32*i -: 32];
      end else begin
        temp = w[i-1];
        if (i % nk == 0) begin
          temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
          rcon = xt(rcon);
        end else if (nk > 6 && i % nk == 4) begin
          temp = sub_word(temp);
        end
        w[i] = w[i-nk] ^ temp;
      end
    end
    for (int r = 0; r < 15; r++)
      rk_tab[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'd0;
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
    logic [7:0]   s[16];
    logic [7:0]   t[16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk_tab[0][127-8*i -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_tab[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rnd != nr) begin
          t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ rk_tab[rnd][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- driver ----------------
  // Presents one block, waits (bounded) until out_valid; lat counts cycles
  // from the accept cycle (0) to the first out_valid cycle.
  task automatic run_block(input logic [127:0] ct, input logic [1:0] m,
                           input bit scramble, output int lat);
    int b;
    b = 0;
    while (!in_ready && b < 50) begin
      @(posedge clk); #1; b++;
    end
    data_in = ct; mode = m; in_valid = 1'b1;
    rk_seen.delete();
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) in_valid = 1'b0;
      if (busy) rk_seen.push_back(rk_index);
      if (out_valid) break;
      if (scramble && busy) begin
        data_in  = {$urandom(), $urandom(), $urandom(), $urandom()};
        mode     = 2'($urandom_range(0, 3));
        in_valid = 1'($urandom_range(0, 1));
      end
    end
    in_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (data_out !== 128'd0) $display("FAIL reset_data_out: got %h expected 0", data_out); else n_pass++;
    n_checks++; if (rk_index !== 4'd0) $display("FAIL reset_rk_index: got %0d expected 0", rk_index); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
  endtask

  task automatic test_fips(input string name, input logic [255:0] key, input int nk,
                           input logic [127:0] ct, input logic [1:0] m, input bit scramble);
    int lat;
    expand_key(key, nk);
    run_block(ct, m, scramble, lat);
    n_checks++; if (lat != nk + 8) $display("FAIL %s_latency: got %0d expected %0d", name, lat, nk + 8); else n_pass++;
    n_checks++; if (data_out !== FIPS_PT) $display("FAIL %s_data: got %h expected %h", name, data_out, FIPS_PT); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL %s_release: got in_ready=%b out_valid=%b expected 1/0", name, in_ready, out_valid); else n_pass++;
  endtask

  task automatic test_aes256_rk_sequence();
    int  lat;
    bit  ok;
    expand_key(KEY_256, 8);
    run_block(CT_256, 2'b10, 1'b0, lat);
    ok = (rk_seen.size() == 15);
    if (ok) for (int i = 0; i < 15; i++) if (rk_seen[i] != 4'(14 - i)) ok = 1'b0;
    n_checks++; if (!ok) $display("FAIL rk_sequence: got %0d entries, first %0d, expected 14..0", rk_seen.size(), (rk_seen.size() > 0) ? rk_seen[0] : 4'd0); else n_pass++;
    n_checks++; if (data_out !== FIPS_PT) $display("FAIL rk_seq_data: got %h expected %h", data_out, FIPS_PT); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int           lat;
    logic [127:0] pt;
    logic [255:0] key;
    expand_key(KEY_128, 4);
    out_ready = 1'b0;
    run_block(CT_128, 2'b00, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (data_out !== FIPS_PT || out_valid !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL bp_hold_%0d: got data=%h ov=%b ir=%b expected %h/1/0", i, data_out, out_valid, in_ready, FIPS_PT);
      else n_pass++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL bp_release: got ir=%b ov=%b expected 1/0", in_ready, out_valid); else n_pass++;
    key = {$urandom(), $urandom(), $urandom(), $urandom(), 128'd0};
    pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
    expand_key(key, 4);
    run_block(encrypt(pt, 10), 2'b00, 1'b0, lat);
    n_checks++; if (data_out !== pt) $display("FAIL b2b_data: got %h expected %h", data_out, pt); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_block();
    int lat;
    bit seen;
    expand_key(KEY_128, 4);
    data_in = CT_128; mode = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || data_out !== 128'd0 || rk_index !== 4'd0)
      $display("FAIL abort_outputs: got busy=%b ov=%b data=%h rk=%0d expected all 0", busy, out_valid, data_out, rk_index);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL abort_in_ready: got %b expected 1", in_ready); else n_pass++;
    seen = 1'b0;
    repeat (20) begin
      if (out_valid || busy) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++; if (seen) $display("FAIL abort_quiet: got activity expected none"); else n_pass++;
    run_block(CT_128, 2'b00, 1'b0, lat);
    n_checks++; if (data_out !== FIPS_PT || lat != 12) $display("FAIL abort_next_block: got %h lat %0d expected %h lat 12", data_out, lat, FIPS_PT); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int           lat;
    int           nk;
    logic [1:0]   m;
    logic [127:0] pt;
    logic [127:0] exp;
    logic [255:0] key;
    for (int n = 0; n < 8; n++) begin
      m   = 2'($urandom_range(0, 3));
      nk  = (m == 2'b00) ? 4 : ((m == 2'b01) ? 6 : 8);
      key = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      expand_key(key, nk);
      exp_q.push_back(pt);
      run_block(encrypt(pt, nk + 6), m, n[0], lat);
      exp = exp_q.pop_front();
      n_checks++; if (lat != nk + 8) $display("FAIL rand%0d_latency: got %0d expected %0d", n, lat, nk + 8); else n_pass++;
      n_checks++; if (data_out !== exp) $display("FAIL rand%0d_data: got %h expected %h (mode %0d)", n, data_out, exp, m); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_pass = 0; n_checks = 0;
    in_valid = 1'b0; out_ready = 1'b1; mode = 2'b00; data_in = 128'd0;
    for (int r = 0; r < 15; r++) rk_tab[r] = 128'd0;
    build_sbox();
    test_reset();
    test_fips("aes128", KEY_128, 4, CT_128, 2'b00, 1'b0);
    test_fips("aes192", KEY_192, 6, CT_192, 2'b01, 1'b0);
    test_fips("aes256", KEY_256, 8, CT_256, 2'b10, 1'b0);
    test_fips("mode11", KEY_256, 8, CT_256, 2'b11, 1'b0);
    test_fips("scramble", KEY_128, 4, CT_128, 2'b00, 1'b1);
    test_aes256_rk_sequence();
    test_back_to_back();
    test_reset_mid_block();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_decrypt_core.md
AES_DECRYPT_CORE -- requirements
Module: aes_decrypt_core

Interface
REQ-001 clk  input  1  single clock; all state changes on the rising edge.
REQ-002 rst_n  input  1  reset, asynchronous and active-low.
REQ-003 mode  input  2  key size, sampled on accept: 00 AES-128 (Nr=10), 01 AES-192 (Nr=12), 10 AES-256 (Nr=14), 11 treated as AES-256.
REQ-004 in_valid  input  1  ciphertext valid.
REQ-005 in_ready  output  1  core can accept a block.
REQ-006 data_in  input  128  ciphertext block, bit 127 = byte 0.
REQ-007 rk_index  output  4  index of the round key needed this cycle.
REQ-008 round_key  input  128  round key for rk_index, valid combinationally in the same cycle; the external key store supplies it.
REQ-009 out_valid  output  1  plaintext valid.
REQ-010 out_ready  input  1  downstream accepts plaintext.
REQ-011 data_out  output  128  plaintext block.
REQ-012 busy  output  1  high in ROUND state.

Function
REQ-013 The FSM SHALL have states IDLE, ROUND and DONE.
- IDLE -> ROUND on in_valid & in_ready.
- ROUND -> DONE after the round-0 cycle.
- DONE -> IDLE on out_ready.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 On accept, the core SHALL perform these latches:
- data_in into the 128-bit state register.
- mode, decoded to Nr.
- round counter loaded with Nr.
REQ-016 In ROUND, rk_index SHALL equal the round counter, and the counter SHALL decrement by 1 each cycle.
REQ-017 When counter == Nr, the state SHALL become state XOR round_key (initial AddRoundKey only).
REQ-018 When Nr > counter > 0, the state SHALL become InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), round_key)).
REQ-019 When counter == 0, the state SHALL become AddRoundKey(InvSubBytes(InvShiftRows(state)), round_key), with InvMixColumns skipped.
REQ-020 Latency: accept in cycle 0; ROUND occupies cycles 1..Nr+1; out_valid first high in cycle Nr+2 (12, 14 or 16 cycles).
REQ-021 In DONE, data_out SHALL hold the state register and stay stable while out_valid & !out_ready.
REQ-022 Handshake sequencing:
- A new block SHALL be accepted no earlier than the cycle after DONE exits; there is no overlap.
- in_ready SHALL not depend combinationally on out_ready.
REQ-023 In ROUND, mode and data_in changes SHALL be ignored; in_valid SHALL have no effect outside IDLE.
REQ-024 In IDLE and DONE, rk_index SHALL be 0.
REQ-025 The counter SHALL never wrap below 0; the decrement from 0 coincides with the exit to DONE.

Reset
REQ-026 On rst_n low, with no clock required, the core SHALL force:
- state IDLE;
- counter 0;
- state register 0;
- in_ready 1 after release, out_valid 0, busy 0, data_out 0, rk_index 0.
REQ-027 Reset asserted in ROUND or DONE SHALL abort the block without emitting out_valid; the first cycle after release is a clean IDLE.

Structure
REQ-028 Package aes_pkg SHALL hold:
- the mode typedef;
- Nr constants 10/12/14;
- the FSM state enum;
- the mode-to-Nr decode function.
REQ-029 One sub-module, aes_inv_rounddata, SHALL hold the combinational inverse round:
- inputs: first flag, last flag, state, round_key;
- contains InvShiftRows, inverse S-box, AddRoundKey and InvMixColumns.
REQ-030 The core SHALL instantiate exactly one aes_inv_rounddata, for one round per cycle.

Verification
REQ-031 AES-128 (FIPS-197 C.1, key 000102..0f, model supplies keys per rk_index): ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, mode 00 -> data_out 00112233445566778899aabbccddeeff, out_valid 12 cycles after accept.
REQ-032 AES-192 (C.2, key 000102..17): ciphertext dda97ca4864cdfe06eaf70a0ec0d7191, mode 01 -> 00112233445566778899aabbccddeeff at 14 cycles; repeat with mode 11 using AES-256 keys and confirm 256 behaviour.
REQ-033 AES-256 (C.3, key 000102..1f): ciphertext 8ea2b7ca516745bfeafc49904b496089, mode 10 -> 00112233445566778899aabbccddeeff at 16 cycles; rk_index sequence 14,13,..,0.
REQ-034 Back-pressure: hold out_ready 0 for 5 cycles -> data_out stable, in_ready 0; then out_ready 1 -> IDLE next cycle, and a back-to-back block decrypts correctly.
REQ-035 Reset in cycle 6 of an AES-128 block -> all outputs 0 and in_ready 1 after release; a following block decrypts correctly.
REQ-036 Toggle mode and data_in during ROUND -> result unchanged from REQ-031.
